// File: rtl/systolic_pkg.sv
// -----------------------------------------------------------------------------
// systolic_pkg
// Shared definitions for the systolic array read-out path:
//   - drain_state_t : accumulator-drain FSM state encoding
//   - ACC_ENTRIES   : accumulator bank size for the default array dimension
//   - sat_hi/sat_lo : signed saturation bounds for a given result width
//   - SAT_HI/SAT_LO : saturation bounds for the default 8-bit result width
// -----------------------------------------------------------------------------
package systolic_pkg;

  localparam int DEFAULT_MATRIX_SIZE = 8;
  localparam int DEFAULT_DATA_WIDTH  = 8;
  localparam int ACC_ENTRIES         = DEFAULT_MATRIX_SIZE * DEFAULT_MATRIX_SIZE;

  // Fixed encodings so the state register stays readable in legacy tooling
  // and waveform filters that only know the raw values.
  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_ISSUE   = 3'd1;
  localparam logic [2:0] ST_CAPTURE = 3'd2;
  localparam logic [2:0] ST_WRITE   = 3'd3;
  localparam logic [2:0] ST_DONE    = 3'd4;

  typedef enum logic [2:0] {
    IDLE    = ST_IDLE,
    ISSUE   = ST_ISSUE,
    CAPTURE = ST_CAPTURE,
    WRITE   = ST_WRITE,
    DONE    = ST_DONE
  } drain_state_t;

  // Number of accumulator entries for an n x n array.
  function automatic int acc_entries(input int n);
    return n * n;
  endfunction

  // Largest / smallest two's-complement value representable in width bits.
  function automatic longint sat_hi(input int width);
    return (64'sd1 <<< (width - 1)) - 64'sd1;
  endfunction

  function automatic longint sat_lo(input int width);
    return -(64'sd1 <<< (width - 1));
  endfunction

  localparam longint SAT_HI = sat_hi(DEFAULT_DATA_WIDTH);
  localparam longint SAT_LO = sat_lo(DEFAULT_DATA_WIDTH);

endpackage

// File: rtl/acc_drain_sequencer_if.sv
// -----------------------------------------------------------------------------
// acc_drain_sequencer_if
// Bus bundle between the drain sequencer and its memories.
//   addr_acc : accumulator read address        (sequencer -> accumulator bank)
//   acc_out  : accumulator read data, 1 cycle after addr_acc (bank -> sequencer)
//   we       : DPRAM write enable / write request (sequencer -> DPRAM arbiter)
//   wr_gnt   : DPRAM write-port grant            (arbiter -> sequencer)
//   addr     : DPRAM write address               (sequencer -> DPRAM)
//   din      : DPRAM write data                  (sequencer -> DPRAM)
// master = sequencer side, slave = memory/arbiter side.
// -----------------------------------------------------------------------------
interface acc_drain_sequencer_if #(
  parameter int ACC_WIDTH      = 32,
  parameter int DATA_WIDTH     = 8,
  parameter int ACC_ADDR_WIDTH = 6,
  parameter int DP_ADDR_WIDTH  = 10
);
  logic [ACC_ADDR_WIDTH-1:0] addr_acc;
  logic [ACC_WIDTH-1:0]      acc_out;
  logic                      wr_gnt;
  logic                      we;
  logic [DP_ADDR_WIDTH-1:0]  addr;
  logic [DATA_WIDTH-1:0]     din;

  modport master (
    output addr_acc, we, addr, din,
    input  acc_out, wr_gnt
  );

  modport slave (
    input  addr_acc, we, addr, din,
    output acc_out, wr_gnt
  );
endinterface

// File: rtl/acc_quantize.sv
// -----------------------------------------------------------------------------
// acc_quantize
// Combinational rescale of a signed accumulator value to a narrow result:
// arithmetic right shift, then either saturate to the signed DATA_WIDTH
// range or keep the low DATA_WIDTH bits.
//   acc_in : signed accumulator value (ACC_WIDTH)
//   shift  : right-shift amount (0..31)
//   sat_en : 1 = saturate, 0 = truncate
//   q      : quantized result (DATA_WIDTH)
// -----------------------------------------------------------------------------
module acc_quantize
  import systolic_pkg::*;
#(
  parameter int ACC_WIDTH  = 32,
  parameter int DATA_WIDTH = 8
) (
  input  logic signed [ACC_WIDTH-1:0] acc_in,
  input  logic [4:0]                  shift,
  input  logic                        sat_en,
  output logic [DATA_WIDTH-1:0]       q
);

  localparam logic signed [ACC_WIDTH-1:0] Q_HI = ACC_WIDTH'(sat_hi(DATA_WIDTH));
  localparam logic signed [ACC_WIDTH-1:0] Q_LO = ACC_WIDTH'(sat_lo(DATA_WIDTH));

  logic signed [ACC_WIDTH-1:0] shifted;

  always_comb begin
    // >>> on a signed operand fills with the sign bit, so shift amounts at or
    // beyond ACC_WIDTH naturally collapse to all sign bits (0 or -1).
    shifted = acc_in >>> shift;
    q       = shifted[DATA_WIDTH-1:0];
    if (sat_en) begin
      if (shifted > Q_HI) begin
        q = Q_HI[DATA_WIDTH-1:0];
      end else if (shifted < Q_LO) begin
        q = Q_LO[DATA_WIDTH-1:0];
      end
    end
  end

endmodule

// File: rtl/acc_drain_sequencer.sv
// -----------------------------------------------------------------------------
// acc_drain_sequencer
// Drains the MATRIX_SIZE x MATRIX_SIZE accumulator bank in row-major order,
// quantizes each entry and writes it to consecutive DPRAM addresses starting
// at a base address, arbitrating for the shared write port with wr_gnt.
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : 1-cycle pulse, begins a drain when idle (wins over abort)
//   abort      : 1-cycle pulse, cancels a drain in progress
//   base_addr  : first DPRAM address       (latched at start)
//   shift      : arithmetic right shift    (latched at start)
//   sat_en     : saturate / truncate select (latched at start)
//   busy       : high while a drain is running
//   done       : 1-cycle pulse after the last write is accepted
//   bus        : accumulator read + DPRAM write bus (master side)
// Each element takes ISSUE -> CAPTURE -> WRITE, three cycles when granted.
// -----------------------------------------------------------------------------
module acc_drain_sequencer
  import systolic_pkg::*;
#(
  parameter int DATA_WIDTH     = DEFAULT_DATA_WIDTH,
  parameter int MATRIX_SIZE    = DEFAULT_MATRIX_SIZE,
  parameter int ACC_WIDTH      = 32,
  parameter int ACC_ADDR_WIDTH = $clog2(MATRIX_SIZE * MATRIX_SIZE),
  parameter int DP_ADDR_WIDTH  = 10
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     abort,
  input  logic [DP_ADDR_WIDTH-1:0] base_addr,
  input  logic [4:0]               shift,
  input  logic                     sat_en,
  output logic                     busy,
  output logic                     done,
  acc_drain_sequencer_if.master    bus
);

  localparam logic [ACC_ADDR_WIDTH-1:0] LAST_IDX =
    ACC_ADDR_WIDTH'(acc_entries(MATRIX_SIZE) - 1);

  drain_state_t              state_reg;
  logic [ACC_ADDR_WIDTH-1:0] idx_reg;
  logic [ACC_ADDR_WIDTH-1:0] idx_next;
  logic [DP_ADDR_WIDTH-1:0]  base_reg;
  logic [4:0]                shift_reg;
  logic                      sat_reg;
  logic [ACC_ADDR_WIDTH-1:0] addr_acc_reg;
  logic                      we_reg;
  logic [DP_ADDR_WIDTH-1:0]  addr_reg;
  logic [DATA_WIDTH-1:0]     din_reg;
  logic                      busy_reg;
  logic                      done_reg;
  logic [DATA_WIDTH-1:0]     q;

  assign idx_next = idx_reg + ACC_ADDR_WIDTH'(1);

  acc_quantize #(
    .ACC_WIDTH (ACC_WIDTH),
    .DATA_WIDTH(DATA_WIDTH)
  ) u_quantize (
    .acc_in(bus.acc_out),
    .shift (shift_reg),
    .sat_en(sat_reg),
    .q     (q)
  );

  // addr_acc is loaded on entry to ISSUE, so the bank's registered read
  // presents acc_out during CAPTURE and the element costs only 3 cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      idx_reg      <= '0;
      base_reg     <= '0;
      shift_reg    <= '0;
      sat_reg      <= 1'b0;
      addr_acc_reg <= '0;
      we_reg       <= 1'b0;
      addr_reg     <= '0;
      din_reg      <= '0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      if (abort && (state_reg != IDLE)) begin
        // A write granted in this same cycle has already been committed by
        // the DPRAM; only the sequencing stops.
        state_reg    <= IDLE;
        we_reg       <= 1'b0;
        busy_reg     <= 1'b0;
        addr_acc_reg <= '0;
      end else begin
        case (state_reg)
          IDLE: begin
            if (start) begin
              base_reg     <= base_addr;
              shift_reg    <= shift;
              sat_reg      <= sat_en;
              idx_reg      <= '0;
              addr_acc_reg <= '0;
              busy_reg     <= 1'b1;
              state_reg    <= ISSUE;
            end
          end
          ISSUE: begin
            state_reg <= CAPTURE;
          end
          CAPTURE: begin
            addr_reg  <= base_reg + DP_ADDR_WIDTH'(idx_reg);
            din_reg   <= q;
            we_reg    <= 1'b1;
            state_reg <= WRITE;
          end
          WRITE: begin
            // Without a grant everything holds; the request stays up.
            if (bus.wr_gnt) begin
              we_reg <= 1'b0;
              if (idx_reg == LAST_IDX) begin
                done_reg  <= 1'b1;
                busy_reg  <= 1'b0;
                state_reg <= DONE;
              end else begin
                idx_reg      <= idx_next;
                addr_acc_reg <= idx_next;
                state_reg    <= ISSUE;
              end
            end
          end
          DONE: begin
            state_reg <= IDLE;
          end
          default: begin
            state_reg <= IDLE;
          end
        endcase
      end
    end
  end

  assign bus.addr_acc = addr_acc_reg;
  assign bus.we       = we_reg;
  assign bus.addr     = addr_reg;
  assign bus.din      = din_reg;
  assign busy         = busy_reg;
  assign done         = done_reg;

endmodule

// File: tb/tb_acc_drain_sequencer.sv
// -----------------------------------------------------------------------------
// tb_acc_drain_sequencer
// Directed bench for acc_drain_sequencer: accumulator bank model with
// registered read, write/done monitor, and a linear sequence of steps.
// -----------------------------------------------------------------------------
module tb_acc_drain_sequencer;
  import systolic_pkg::*;

  localparam int DW  = 8;
  localparam int N   = 8;
  localparam int AW  = 32;
  localparam int AAW = 6;
  localparam int DPW = 10;
  localparam int NE  = N * N;
  localparam int TMO = 400;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           start = 1'b0;
  logic           abort = 1'b0;
  logic           sat_en = 1'b0;
  logic [DPW-1:0] base_addr = '0;
  logic [4:0]     shift = '0;
  logic           busy;
  logic           done;

  acc_drain_sequencer_if #(
    .ACC_WIDTH(AW), .DATA_WIDTH(DW), .ACC_ADDR_WIDTH(AAW), .DP_ADDR_WIDTH(DPW)
  ) bus ();

  acc_drain_sequencer #(
    .DATA_WIDTH(DW), .MATRIX_SIZE(N), .ACC_WIDTH(AW),
    .ACC_ADDR_WIDTH(AAW), .DP_ADDR_WIDTH(DPW)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .abort    (abort),
    .base_addr(base_addr),
    .shift    (shift),
    .sat_en   (sat_en),
    .busy     (busy),
    .done     (done),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  // Accumulator bank: registered read.
  logic [AW-1:0] acc_mem [NE];
  always @(posedge clk) bus.acc_out <= acc_mem[bus.addr_acc];

  // cyc = number of rising edges so far; the next edge has index cyc.
  int cyc = 0;
  always @(posedge clk) cyc++;

  // Monitor, sampled 1 time unit after each falling edge: a write seen here
  // with we && wr_gnt commits on the coming edge (index cyc).
  int wr_cnt = 0;
  int done_cnt = 0;
  int done_edge = 0;
  int log_addr [2048];
  int log_din  [2048];
  int log_edge [2048];
  always @(negedge clk) begin
    #1;
    if (rst_n && bus.we && bus.wr_gnt && wr_cnt < 2048) begin
      log_addr[wr_cnt] = int'(bus.addr);
      log_din[wr_cnt]  = int'(bus.din);
      log_edge[wr_cnt] = cyc;
      wr_cnt++;
    end
    if (rst_n && done) begin
      done_cnt++;
      done_edge = cyc;
    end
  end

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic pulse_abort();
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
  endtask

  // Wait (bounded) until done_cnt moves past d0.
  task automatic wait_done(input int d0, output int t);
    t = 0;
    while (done_cnt == d0 && t < TMO) begin
      @(negedge clk);
      t++;
    end
  endtask

  // Wait (bounded) until wr_cnt reaches target.
  task automatic wait_writes(input int target, output int t);
    t = 0;
    while (wr_cnt < target && t < TMO) begin
      @(negedge clk);
      t++;
    end
  endtask

  // Run a drain with acc[0]=val, capture the first written value, then abort.
  task automatic first_write(input logic [AW-1:0] val, input logic [4:0] sh,
                             input logic sat, output int d, output int t);
    int w0;
    acc_mem[0] = val;
    shift = sh;
    sat_en = sat;
    base_addr = '0;
    w0 = wr_cnt;
    pulse_start();
    wait_writes(w0 + 1, t);
    d = log_din[w0];
    pulse_abort();
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int t0, t1, w0, w1, d0, tmo, dq;
    logic [DPW-1:0] a_hold;
    logic [DW-1:0]  d_hold;

    for (int i = 0; i < NE; i++) acc_mem[i] = AW'(i);
    bus.wr_gnt = 1'b1;

    // ---- reset state --------------------------------------------------------
    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_we", 64'(bus.we), 64'd0);
    chk("rst_addr", 64'(bus.addr), 64'd0);
    chk("rst_din", 64'(bus.din), 64'd0);
    chk("rst_addr_acc", 64'(bus.addr_acc), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // ---- abort while idle does nothing --------------------------------------
    pulse_abort();
    chk("idle_abort_busy", 64'(busy), 64'd0);
    chk("idle_abort_we", 64'(bus.we), 64'd0);

    // ---- full drain: acc[i]=i, base 0x100, shift 0, saturate -------------------
    base_addr = 10'h100; shift = 5'd0; sat_en = 1'b1;
    w0 = wr_cnt; d0 = done_cnt; t0 = cyc;
    pulse_start();
    chk("busy_after_start", 64'(busy), 64'd1);
    wait_done(d0, tmo);
    chk("full_timeout", 64'(tmo < TMO), 64'd1);
    chk("full_done_cnt", 64'(done_cnt - d0), 64'd1);
    chk("full_wr_cnt", 64'(wr_cnt - w0), 64'd64);
    chk("full_first_req_edge", 64'(log_edge[w0] - t0), 64'd3);
    chk("full_last_wr_edge", 64'(log_edge[w0 + 63] - t0), 64'd192);
    chk("full_done_edge", 64'(done_edge - t0), 64'd193);
    for (int k = 0; k < NE; k++) begin
      chk($sformatf("full_addr[%0d]", k), 64'(log_addr[w0 + k]), 64'(32'h100 + k));
      chk($sformatf("full_din[%0d]", k), 64'(log_din[w0 + k]), 64'(k));
    end
    chk("full_busy_end", 64'(busy), 64'd0);
    chk("full_done_end", 64'(done), 64'd0);

    // ---- quantization ----------------------------------------------------
    first_write(32'h0000_1234, 5'd4, 1'b1, dq, tmo);
    chk("q_pos_sat", 64'(dq), 64'h7F);
    chk("q_abort_busy", 64'(busy), 64'd0);
    first_write(32'h0000_1234, 5'd4, 1'b0, dq, tmo);
    chk("q_pos_trunc", 64'(dq), 64'h23);
    first_write(32'hFFFF_F000, 5'd4, 1'b1, dq, tmo);
    chk("q_neg_sat", 64'(dq), 64'h80);
    first_write(32'hFFFF_F000, 5'd4, 1'b0, dq, tmo);
    chk("q_neg_trunc", 64'(dq), 64'h00);
    first_write(32'h8000_0000, 5'd31, 1'b1, dq, tmo);
    chk("q_shift31_neg", 64'(dq), 64'hFF);
    chk("q_timeout", 64'(tmo < TMO), 64'd1);
    acc_mem[0] = '0;

    // ---- address wrap at base 0x3FE -------------------------------------------
    base_addr = 10'h3FE; shift = 5'd0; sat_en = 1'b1;
    w0 = wr_cnt; d0 = done_cnt;
    pulse_start();
    wait_writes(w0 + 3, tmo);
    pulse_abort();
    chk("wrap_addr0", 64'(log_addr[w0]), 64'h3FE);
    chk("wrap_addr1", 64'(log_addr[w0 + 1]), 64'h3FF);
    chk("wrap_addr2", 64'(log_addr[w0 + 2]), 64'h000);
    chk("wrap_din2", 64'(log_din[w0 + 2]), 64'd2);
    chk("wrap_no_done", 64'(done_cnt - d0), 64'd0);

    // ---- stall 5 cycles on first write; start during busy ignored ------------
    base_addr = 10'h100;
    bus.wr_gnt = 1'b0;
    w0 = wr_cnt; d0 = done_cnt; t0 = cyc;
    pulse_start();
    tmo = 0;
    while (bus.we !== 1'b1 && tmo < 20) begin
      @(negedge clk);
      tmo++;
    end
    chk("stall_req_seen", 64'(bus.we), 64'd1);
    a_hold = bus.addr;
    d_hold = bus.din;
    chk("stall_addr0", 64'(a_hold), 64'h100);
    for (int s = 0; s < 5; s++) begin
      @(negedge clk);
      chk($sformatf("stall_we[%0d]", s), 64'(bus.we), 64'd1);
      chk($sformatf("stall_addr[%0d]", s), 64'(bus.addr), 64'(a_hold));
      chk($sformatf("stall_din[%0d]", s), 64'(bus.din), 64'(d_hold));
    end
    bus.wr_gnt = 1'b1;
    repeat (30) @(negedge clk);
    base_addr = 10'h200; shift = 5'd3; sat_en = 1'b0;
    pulse_start();
    wait_done(d0, tmo);
    chk("stall_done_edge", 64'(done_edge - t0), 64'd198);
    chk("stall_first_wr_edge", 64'(log_edge[w0] - t0), 64'd8);
    chk("stall_wr_cnt", 64'(wr_cnt - w0), 64'd64);
    chk("stall_last_addr", 64'(log_addr[w0 + 63]), 64'h13F);
    chk("stall_last_din", 64'(log_din[w0 + 63]), 64'd63);
    shift = 5'd0; sat_en = 1'b1;

    // ---- abort at 10th write request, then restart ----------------------------
    base_addr = 10'h000;
    w0 = wr_cnt; d0 = done_cnt;
    pulse_start();
    wait_writes(w0 + 9, tmo);
    bus.wr_gnt = 1'b0;
    tmo = 0;
    while (bus.we !== 1'b1 && tmo < 20) begin
      @(negedge clk);
      tmo++;
    end
    chk("abort_req10_addr", 64'(bus.addr), 64'd9);
    chk("abort_req10_din", 64'(bus.din), 64'd9);
    pulse_abort();
    chk("abort_we", 64'(bus.we), 64'd0);
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_addr_acc", 64'(bus.addr_acc), 64'd0);
    chk("abort_wr_cnt", 64'(wr_cnt - w0), 64'd9);
    repeat (10) @(negedge clk);
    chk("abort_no_done", 64'(done_cnt - d0), 64'd0);
    bus.wr_gnt = 1'b1;
    base_addr = 10'h050;
    w1 = wr_cnt; t1 = cyc;
    pulse_start();
    wait_done(d0, tmo);
    chk("restart_addr0", 64'(log_addr[w1]), 64'h050);
    chk("restart_din0", 64'(log_din[w1]), 64'd0);
    chk("restart_wr_cnt", 64'(wr_cnt - w1), 64'd64);
    chk("restart_done_edge", 64'(done_edge - t1), 64'd193);

    // ---- start and abort together while idle: start wins ----------------------
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    chk("start_abort_busy", 64'(busy), 64'd1);
    pulse_abort();
    chk("start_abort_cleared", 64'(busy), 64'd0);

    // ---- asynchronous reset mid-drain ---------------------------------------
    d0 = done_cnt;
    base_addr = 10'h100;
    pulse_start();
    repeat (20) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_done", 64'(done), 64'd0);
    chk("arst_we", 64'(bus.we), 64'd0);
    chk("arst_addr", 64'(bus.addr), 64'd0);
    chk("arst_din", 64'(bus.din), 64'd0);
    chk("arst_addr_acc", 64'(bus.addr_acc), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("arst_stays_idle", 64'(busy), 64'd0);
    chk("arst_no_done", 64'(done_cnt - d0), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
